// File: rtl/hdmi_mode_sequencer.sv
// rtl/hdmi_mode_sequencer.sv - NTSC/PAL switch sequencer ahead of the HDMI selection/serialiser stage
//
// Purpose: on a change of pal_mode_req, blank video and mute audio at a line
// boundary, hold the HDMI encoders in reset while the mode flips, then wait
// SETTLE_FRAMES clean frame starts before passing video and audio again.
// Reset performs the same sequence as power-up.
//
// Optional feature macro: HDMI_SEQ_DEBOUNCE_EN (request debounced over
// DEBOUNCE_CYCLES consecutive mismatching cycles before any transition).
//
// Ports:
//   clk_pixel     in   pixel clock, sole clock
//   reset         in   synchronous, active-high
//   pal_mode_req  in   requested mode (1 = PAL, 0 = NTSC)
//   rgb_in[23:0]  in   pixel colour from the VDP
//   cx[11:0]      in   current pixel x from the HDMI stage
//   cy[10:0]      in   current pixel y from the HDMI stage
//   pal_mode      out  active mode to the HDMI stage
//   hdmi_reset    out  reset to the HDMI encoders
//   rgb_out[23:0] out  pixel colour to the HDMI stage
//   audio_mute    out  1 = downstream audio forced to zero
//   busy          out  1 whenever not in RUN
module hdmi_mode_sequencer #(
    parameter int RESET_CYCLES    = 16,
    parameter int SETTLE_FRAMES   = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        pal_mode_req,
    input  logic [23:0] rgb_in,
    input  logic [11:0] cx,
    input  logic [10:0] cy,
    output logic        pal_mode,
    output logic        hdmi_reset,
    output logic [23:0] rgb_out,
    output logic        audio_mute,
    output logic        busy
);

    // Elaboration-time range guards for the parameters.
    if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
        $error("RESET_CYCLES out of range 1..255");
    end
    if (SETTLE_FRAMES < 1 || SETTLE_FRAMES > 15) begin : g_bad_settle_frames
        $error("SETTLE_FRAMES out of range 1..15");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce_cycles
        $error("DEBOUNCE_CYCLES out of range 1..15");
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BLANK,
        ST_HOLD_RESET,
        ST_SETTLE
    } state_t;

    // Terminal values: counters stop here, so they can never wrap.
    localparam logic [7:0] RST_LAST    = 8'(RESET_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

    state_t      state, state_nxt;
    logic [7:0]  rst_cnt, rst_cnt_nxt;
    logic [3:0]  settle_cnt, settle_cnt_nxt;
    logic        origin_d;
    logic        pal_mode_nxt;
    logic        hdmi_reset_nxt;
    logic [23:0] rgb_out_nxt;
    logic        audio_mute_nxt;
    logic        busy_nxt;

    logic at_origin;
    logic fs;
    logic mismatch;
    logic switch_req;

    assign at_origin = (cx == 12'd0) && (cy == 11'd0);
    // Only the first cycle at the origin counts, however long the raster sits there.
    assign fs        = at_origin && !origin_d;
    assign mismatch  = (pal_mode_req != pal_mode);

`ifdef HDMI_SEQ_DEBOUNCE_EN
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic [3:0] db_cnt, db_cnt_nxt;

    // Act on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
    assign switch_req = mismatch && (db_cnt == DB_LAST);

    always_comb begin
        db_cnt_nxt = 4'd0;
        if (mismatch && !switch_req && state != ST_BLANK) begin
            db_cnt_nxt = db_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            db_cnt <= 4'd0;
        end else begin
            db_cnt <= db_cnt_nxt;
        end
    end
`else
    assign switch_req = mismatch;
`endif

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state      <= ST_HOLD_RESET;
            pal_mode   <= pal_mode_req;
            hdmi_reset <= 1'b1;
            rgb_out    <= 24'h000000;
            audio_mute <= 1'b1;
            busy       <= 1'b1;
            rst_cnt    <= 8'd0;
            settle_cnt <= 4'd0;
            origin_d   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pal_mode   <= pal_mode_nxt;
            hdmi_reset <= hdmi_reset_nxt;
            rgb_out    <= rgb_out_nxt;
            audio_mute <= audio_mute_nxt;
            busy       <= busy_nxt;
            rst_cnt    <= rst_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            origin_d   <= at_origin;
        end
    end

    // Next-state and next-output logic; the *_nxt values are what the
    // outputs hold in the cycle after the edge.
    always_comb begin
        state_nxt      = state;
        rst_cnt_nxt    = rst_cnt;
        settle_cnt_nxt = settle_cnt;
        pal_mode_nxt   = pal_mode;
        hdmi_reset_nxt = 1'b0;
        rgb_out_nxt    = 24'h000000;
        audio_mute_nxt = 1'b1;
        busy_nxt       = 1'b1;

        case (state)
            ST_RUN: begin
                rgb_out_nxt    = rgb_in;
                audio_mute_nxt = 1'b0;
                busy_nxt       = 1'b0;
                if (switch_req) begin
                    state_nxt      = ST_BLANK;
                    rgb_out_nxt    = 24'h000000;
                    audio_mute_nxt = 1'b1;
                    busy_nxt       = 1'b1;
                end
            end

            ST_BLANK: begin
                // Switch at a line start even if the request has reverted,
                // so the encoders always see a clean reset.
                if (cx == 12'd0) begin
                    state_nxt      = ST_HOLD_RESET;
                    pal_mode_nxt   = pal_mode_req;
                    rst_cnt_nxt    = 8'd0;
                    hdmi_reset_nxt = 1'b1;
                end
            end

            ST_HOLD_RESET: begin
                hdmi_reset_nxt = 1'b1;
                if (switch_req) begin
                    // A new request restarts the full hold with the new mode.
                    pal_mode_nxt = pal_mode_req;
                    rst_cnt_nxt  = 8'd0;
                end else if (rst_cnt == RST_LAST) begin
                    state_nxt      = ST_SETTLE;
                    hdmi_reset_nxt = 1'b0;
                    settle_cnt_nxt = 4'd0;
                end else begin
                    rst_cnt_nxt = rst_cnt + 8'd1;
                end
            end

            ST_SETTLE: begin
                if (switch_req) begin
                    state_nxt      = ST_HOLD_RESET;
                    pal_mode_nxt   = pal_mode_req;
                    rst_cnt_nxt    = 8'd0;
                    settle_cnt_nxt = 4'd0;
                    hdmi_reset_nxt = 1'b1;
                end else if (fs) begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt      = ST_RUN;
                        settle_cnt_nxt = 4'd0;
                        audio_mute_nxt = 1'b0;
                        busy_nxt       = 1'b0;
                    end else begin
                        settle_cnt_nxt = settle_cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_nxt      = ST_HOLD_RESET;
                rst_cnt_nxt    = 8'd0;
                hdmi_reset_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// tb/tb_hdmi_mode_sequencer.sv - directed self-checking bench for hdmi_mode_sequencer
module tb_hdmi_mode_sequencer;

`ifdef HDMI_SEQ_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 1;
`endif

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        pal_mode_req;
    logic [23:0] rgb_in;
    logic [11:0] cx;
    logic [10:0] cy;
    logic        pal_mode;
    logic        hdmi_reset;
    logic [23:0] rgb_out;
    logic        audio_mute;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_mode_sequencer #(
        .RESET_CYCLES    (16),
        .SETTLE_FRAMES   (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .pal_mode_req (pal_mode_req),
        .rgb_in       (rgb_in),
        .cx           (cx),
        .cy           (cy),
        .pal_mode     (pal_mode),
        .hdmi_reset   (hdmi_reset),
        .rgb_out      (rgb_out),
        .audio_mute   (audio_mute),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_pixel);
    endtask

    // Cycles until hdmi_reset drops, bounded so a stuck reset still terminates.
    task automatic hold_len(output int n);
        n = 0;
        while (hdmi_reset === 1'b1 && n < 300) begin
            step(1);
            n++;
        end
    endtask

    // Raster at the origin for len cycles, then back off it for one cycle.
    task automatic frame_start(input int len);
        cx = 12'd0;
        cy = 11'd0;
        step(len);
        cx = 12'd5;
        cy = 11'd5;
        step(1);
    endtask

    int n;
    int tot;

    initial begin
        reset        = 1'b1;
        pal_mode_req = 1'b1;
        rgb_in       = 24'h123456;
        cx           = 12'd5;
        cy           = 11'd5;
        step(2);
        reset = 1'b0;

        // Power-up sequence.
        check("rst_pal_mode", 32'(pal_mode), 32'd1);
        check("rst_hdmi_reset", 32'(hdmi_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_audio_mute", 32'(audio_mute), 32'd1);
        check("rst_rgb_out", 32'(rgb_out), 32'h0);
        hold_len(n);
        check("pwrup_hold_len", 32'(n), 32'd16);
        check("pwrup_busy_settle", 32'(busy), 32'd1);
        frame_start(1);
        check("pwrup_one_fs_busy", 32'(busy), 32'd1);
        cx = 12'd0;
        cy = 11'd0;
        step(1);
        check("pwrup_run_busy", 32'(busy), 32'd0);
        check("pwrup_run_mute", 32'(audio_mute), 32'd0);
        check("pwrup_first_pix_lat", 32'(rgb_out), 32'h0);
        cx = 12'd5;
        cy = 11'd5;
        step(1);
        check("pwrup_pix", 32'(rgb_out), 32'h123456);

        // PAL -> NTSC mid-line, single origin held for 5 cycles.
        rgb_in       = 24'hABCDEF;
        cx           = 12'd500;
        pal_mode_req = 1'b0;
        step(DB);
        check("b_blank_rgb", 32'(rgb_out), 32'h0);
        check("b_blank_mute", 32'(audio_mute), 32'd1);
        check("b_blank_pal", 32'(pal_mode), 32'd1);
        step(3);
        check("b_wait_line_pal", 32'(pal_mode), 32'd1);
        check("b_wait_line_hr", 32'(hdmi_reset), 32'd0);
        cx = 12'd0;
        step(1);
        check("b_switch_pal", 32'(pal_mode), 32'd0);
        check("b_switch_hr", 32'(hdmi_reset), 32'd1);
        cx = 12'd5;
        hold_len(n);
        check("b_hold_len", 32'(n), 32'd16);
        frame_start(5);
        step(3);
        check("b_held_origin_one_fs", 32'(busy), 32'd1);
        cx = 12'd0;
        cy = 11'd0;
        step(1);
        check("b_run_busy", 32'(busy), 32'd0);
        cx = 12'd5;
        cy = 11'd5;
        step(1);
        check("b_run_pix", 32'(rgb_out), 32'hABCDEF);

        // NTSC -> PAL, request reverted during the hold.
        pal_mode_req = 1'b1;
        cx           = 12'd500;
        step(DB);
        check("c_blank_rgb", 32'(rgb_out), 32'h0);
        check("c_blank_mute", 32'(audio_mute), 32'd1);
        check("c_blank_pal", 32'(pal_mode), 32'd0);
        cx = 12'd0;
        step(1);
        check("c_switch_pal", 32'(pal_mode), 32'd1);
        check("c_switch_hr", 32'(hdmi_reset), 32'd1);
        cx = 12'd5;
        step(9);
        pal_mode_req = 1'b0;
        step(DB);
        check("c_revert_pal", 32'(pal_mode), 32'd0);
        check("c_revert_hr", 32'(hdmi_reset), 32'd1);
        hold_len(n);
        tot = 9 + DB + n;
        check("c_further_hold", 32'(n), 32'd16);
        check("c_total_hold", 32'(tot), 32'(26 + DB - 1));

        // Request changes in SETTLE after one fs: settle count must restart.
        frame_start(1);
        pal_mode_req = 1'b1;
        step(DB);
        check("d_rehold_hr", 32'(hdmi_reset), 32'd1);
        check("d_rehold_pal", 32'(pal_mode), 32'd1);
        check("d_rehold_busy", 32'(busy), 32'd1);
        hold_len(n);
        check("d_hold_len", 32'(n), 32'd16);
        frame_start(1);
        step(2);
        check("d_cnt_cleared", 32'(busy), 32'd1);
        cx = 12'd0;
        cy = 11'd0;
        step(1);
        check("d_run_busy", 32'(busy), 32'd0);
        check("d_run_mute", 32'(audio_mute), 32'd0);
        cx = 12'd5;
        cy = 11'd5;
        step(1);

        // Request reverts in BLANK: sequence still completes.
        cx           = 12'd500;
        pal_mode_req = 1'b0;
        step(DB);
        pal_mode_req = 1'b1;
        step(2);
        check("e_blank_busy", 32'(busy), 32'd1);
        check("e_blank_hr", 32'(hdmi_reset), 32'd0);
        cx = 12'd0;
        step(1);
        check("e_switch_hr", 32'(hdmi_reset), 32'd1);
        check("e_switch_pal", 32'(pal_mode), 32'd1);
        cx = 12'd5;
        hold_len(n);
        check("e_hold_len", 32'(n), 32'd16);
        frame_start(1);
        frame_start(1);
        check("e_run_busy", 32'(busy), 32'd0);

        // Short request pulses.
`ifdef HDMI_SEQ_DEBOUNCE_EN
        pal_mode_req = 1'b0;
        step(3);
        pal_mode_req = 1'b1;
        step(2);
        check("f_pulse3_busy", 32'(busy), 32'd0);
        pal_mode_req = 1'b0;
        step(3);
        check("f_pulse4_pre", 32'(busy), 32'd0);
        step(1);
        check("f_pulse4_busy", 32'(busy), 32'd1);
`else
        pal_mode_req = 1'b0;
        step(1);
        pal_mode_req = 1'b1;
        check("f_pulse1_busy", 32'(busy), 32'd1);
        check("f_pulse1_mute", 32'(audio_mute), 32'd1);
`endif

        // Reset mid-sequence restarts with the sampled request.
        pal_mode_req = 1'b0;
        reset        = 1'b1;
        step(1);
        reset = 1'b0;
        check("g_rst_pal", 32'(pal_mode), 32'd0);
        check("g_rst_hr", 32'(hdmi_reset), 32'd1);
        check("g_rst_rgb", 32'(rgb_out), 32'h0);
        check("g_rst_busy", 32'(busy), 32'd1);
        hold_len(n);
        check("g_hold_len", 32'(n), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
